// File: rtl/mdu_pkg.sv
// Shared encodings and widths for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_DIV  = 2'b01,
    MDU_MTHI = 2'b10,
    MDU_MTLO = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/DIV unit with HI/LO pair: 32 shift-add or restoring shift-subtract steps,
// then one sign-fix cycle. MTHI/MTLO write HI/LO directly from A.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO handled here
// MUL   | one partial product per cycle on unsigned magnitudes
// DIV   | one quotient bit per cycle on unsigned magnitudes
// FIX   | apply sign correction, write HI/LO, pulse Done
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic                 is_div_q, is_div_d, dbz_pend_q, dbz_pend_d;
  logic                 dbz_q, dbz_d, done_q, done_d;

  logic                 a_neg, b_neg, launch, div_ge;
  logic [WIDTH-1:0]     mag_a, mag_b, quo_fix, rem_fix, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH:0]       mul_sum, div_tmp;

  assign a_neg = Signed & A[WIDTH-1];
  assign b_neg = Signed & B[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH))   u_mag_a (.val_i(A), .neg_i(a_neg), .res_o(mag_a));
  mdu_sign_fix #(.W(WIDTH))   u_mag_b (.val_i(B), .neg_i(b_neg), .res_o(mag_b));
  mdu_sign_fix #(.W(2*WIDTH)) u_prod  (.val_i(work_q), .neg_i(neg_res_q), .res_o(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_quo   (.val_i(work_q[WIDTH-1:0]), .neg_i(neg_res_q), .res_o(quo_fix));
  mdu_sign_fix #(.W(WIDTH))   u_rem   (.val_i(work_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix));

  // work_q holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign div_tmp  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_ge   = div_tmp >= {1'b0, opnd_q};
  assign div_diff = div_tmp[WIDTH-1:0] - opnd_q;

  // Arithmetic starts are also taken in FIX so back-to-back ops keep Busy high
  assign launch = Start && (Op == MDU_MUL || Op == MDU_DIV) &&
                  (state_q == S_IDLE || state_q == S_FIX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && Op == MDU_MTHI) begin
          hi_d   = A;
          done_d = 1'b1;
          dbz_d  = 1'b0;
        end else if (Start && Op == MDU_MTLO) begin
          lo_d   = A;
          done_d = 1'b1;
          dbz_d  = 1'b0;
        end
      end
      S_MUL: begin
        work_d = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]} : {1'b0, work_q[2*WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        work_d = div_ge ? {div_diff, work_q[WIDTH-2:0], 1'b1}
                        : {div_tmp[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide-by-zero leaves |A| in the remainder, so rem_fix restores A itself
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dbz_pend_q ? '1 : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        dbz_d   = dbz_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d    = (Op == MDU_MUL) ? S_MUL : S_DIV;
      is_div_d   = (Op == MDU_DIV);
      work_d     = {{WIDTH{1'b0}}, (Op == MDU_MUL) ? mag_b : mag_a};
      opnd_d     = (Op == MDU_MUL) ? mag_a : mag_b;
      neg_res_d  = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      dbz_pend_d = (Op == MDU_DIV) && (B == '0);
      cnt_d      = '0;
      if (state_q == S_IDLE) dbz_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus MTHI/MTLO, busy-ignore, back-to-back and reset sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Start, Signed;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs [11];

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Signed(Signed),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; exp_busy counts Busy cycles still ahead.
  task automatic wait_result(input string nm, input int exp_busy, input logic [31:0] eh,
                             input logic [31:0] el, input logic ed);
    int busy_n = 0;
    bit got    = 1'b0;
    bit held   = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (Done === 1'b1) got = 1'b1;
      else begin
        if (Busy === 1'b1) busy_n++;
        if (Hi !== m_hi || Lo !== m_lo) held = 1'b0;
        @(negedge clk);
      end
    end
    chk({nm, " done_seen"}, 64'(got), 64'd1);
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({nm, " hilo_held"}, 64'(held), 64'd1);
    chk({nm, " busy_at_done"}, 64'(Busy), 64'd0);
    chk({nm, " hi"}, 64'(Hi), 64'(eh));
    chk({nm, " lo"}, 64'(Lo), 64'(el));
    chk({nm, " divbyzero"}, 64'(DivByZero), 64'(ed));
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  task automatic run_arith(input string nm, input vec_t v);
    Start = 1'b1; Op = v.op; Signed = v.sgn; A = v.a; B = v.b;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    wait_result(nm, 33, v.hi, v.lo, v.dbz);
  endtask

  initial begin
    vec_t v;
    int   busy_n;
    bit   got;

    reset = 1'b1; Start = 1'b0; Op = 2'b00; Signed = 1'b0; A = '0; B = '0;

    vecs[0]  = '{MDU_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{MDU_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{MDU_DIV, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{MDU_DIV, 1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{MDU_MUL, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,         32'd6,         1'b0};
    vecs[7]  = '{MDU_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{MDU_MUL, 1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0};
    vecs[9]  = '{MDU_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{MDU_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};

    repeat (2) @(negedge clk);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    chk("reset dbz", 64'(DivByZero), 64'd0);
    chk("reset hi", 64'(Hi), 64'd0);
    chk("reset lo", 64'(Lo), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_arith($sformatf("vec%0d", i), vecs[i]);

    // MTHI then MTLO: one edge each, Done pulses, never busy
    Start = 1'b1; Op = MDU_MTHI; A = 32'h1234_5678;
    @(negedge clk);
    Start = 1'b0; A = $urandom;
    chk("mthi hi", 64'(Hi), 64'h1234_5678);
    chk("mthi lo_kept", 64'(Lo), 64'(m_lo));
    chk("mthi done", 64'(Done), 64'd1);
    chk("mthi busy", 64'(Busy), 64'd0);
    m_hi = 32'h1234_5678;
    Start = 1'b1; Op = MDU_MTLO; A = 32'h9ABC_DEF0;
    @(negedge clk);
    Start = 1'b0; A = $urandom;
    chk("mtlo lo", 64'(Lo), 64'h9ABC_DEF0);
    chk("mtlo hi_kept", 64'(Hi), 64'h1234_5678);
    chk("mtlo done", 64'(Done), 64'd1);
    chk("mtlo busy", 64'(Busy), 64'd0);
    m_lo = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo done_pulse", 64'(Done), 64'd0);

    // MTHI while busy must be ignored
    Start = 1'b1; Op = MDU_MUL; Signed = 1'b0; A = 32'd3; B = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Start = 1'b1; Op = MDU_MTHI; A = 32'hDEAD_BEEF;
    @(negedge clk);
    Start = 1'b0;
    chk("busy_mthi hi_kept", 64'(Hi), 64'h1234_5678);
    chk("busy_mthi done", 64'(Done), 64'd0);
    wait_result("busy_mthi", 28, 32'd0, 32'd15, 1'b0);

    // Back-to-back: DIV accepted on the edge MUL's Done rises
    Start = 1'b1; Op = MDU_MUL; Signed = 1'b0; A = 32'd6; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (32) @(negedge clk);
    chk("b2b busy_fix", 64'(Busy), 64'd1);
    Start = 1'b1; Op = MDU_DIV; Signed = 1'b0; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; A = $urandom; B = $urandom;
    chk("b2b done1", 64'(Done), 64'd1);
    chk("b2b busy_kept", 64'(Busy), 64'd1);
    chk("b2b hi1", 64'(Hi), 64'd0);
    chk("b2b lo1", 64'(Lo), 64'd42);
    m_hi = 32'd0;
    m_lo = 32'd42;
    @(negedge clk);
    wait_result("b2b div", 32, 32'd2, 32'd14, 1'b0);

    // Reset mid-operation, then an immediate DIV
    Start = 1'b1; Op = MDU_MUL; Signed = 1'b0; A = 32'd3; B = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(Busy), 64'd0);
    chk("midrst done", 64'(Done), 64'd0);
    chk("midrst hi", 64'(Hi), 64'd0);
    chk("midrst lo", 64'(Lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    reset = 1'b0;
    v = '{MDU_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    run_arith("midrst div", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
